// File: rtl/seg_round_tracker_if.sv
// ---------------------------------------------------------------------------
// seg_round_tracker_if
// Groups the game-control and status signals of seg_round_tracker.
//   count_in   : 3-bit free-running value from the upstream 1 Hz counter
//   start      : level, starts or re-arms a game
//   pause      : level, holds the game while high
//   round      : 4-bit completed-wrap count of the current game
//   state      : 2-bit FSM state (IDLE=00, RUN=01, PAUSE=10, DONE=11)
//   wrap_pulse : one-cycle pulse for each counted wrap
//   game_over  : high while state is DONE
//   step_err   : sticky illegal-step flag
// master modport drives the controls, slave modport is the tracker itself.
// ---------------------------------------------------------------------------
interface seg_round_tracker_if;
  logic [2:0] count_in;
  logic       start;
  logic       pause;
  logic [3:0] round;
  logic [1:0] state;
  logic       wrap_pulse;
  logic       game_over;
  logic       step_err;

  modport master (
    output count_in, start, pause,
    input  round, state, wrap_pulse, game_over, step_err
  );

  modport slave (
    input  count_in, start, pause,
    output round, state, wrap_pulse, game_over, step_err
  );
endinterface

// File: rtl/seg_round_tracker.sv
// ---------------------------------------------------------------------------
// seg_round_tracker
// Counts 7->0 wraps of an upstream 0..7 counter as game rounds. A game runs
// until MAX_ROUNDS wraps have been counted, can be paused, and is re-armed
// through IDLE with start.
// Ports:
//   clk_1H : 1 Hz game tick, all state changes on its rising edge
//   reset  : asynchronous, active-high
//   bus    : seg_round_tracker_if.slave (count_in/start/pause in,
//            round/state/wrap_pulse/game_over/step_err out)
// Parameter:
//   MAX_ROUNDS : wraps that end a game, 1..15, default 9
// Optional feature:
//   SEG_ROUND_TRACKER_STEP_CHECK_EN : when defined, flags count_in steps that
//   are neither a hold nor +1 (mod 8) while running. When undefined step_err
//   is tied low and no check logic exists.
// ---------------------------------------------------------------------------
module seg_round_tracker #(
  parameter int MAX_ROUNDS = 9
) (
  input  logic               clk_1H,
  input  logic               reset,
  seg_round_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [3:0] ROUND_LAST = 4'(MAX_ROUNDS - 1);

  state_t     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic       wrap_pulse_q, wrap_pulse_d;
  logic       game_over_q;
  logic [2:0] prev_count;
  logic       prev_valid;
  logic       wrap;

  // A wrap needs a real previous sample, so the first edge after reset can
  // never produce one even if the counter happens to read 0.
  assign wrap = prev_valid && (prev_count == 3'd7) && (bus.count_in == 3'd0);

  // Input history, tracked in every state so wrap detection is ready the
  // moment a game starts.
  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset) begin
      prev_count <= 3'd0;
      prev_valid <= 1'b0;
    end else begin
      prev_count <= bus.count_in;
      prev_valid <= 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. The terminal wrap wins over pause; start only matters
  // in IDLE and DONE, and DONE always goes back through IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.start) state_d = RUN;
      RUN: begin
        if (wrap && (round_q == ROUND_LAST)) state_d = DONE;
        else if (bus.pause)                  state_d = PAUSE;
      end
      PAUSE: if (!bus.pause) state_d = RUN;
      DONE:  if (bus.start)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values. Only RUN counts wraps, which also covers a wrap on
  // the same edge that pause goes high. round is held in PAUSE, DONE and in
  // IDLE until the next start clears it.
  always_comb begin
    round_d      = round_q;
    wrap_pulse_d = 1'b0;
    case (state_q)
      IDLE: if (bus.start) round_d = 4'd0;
      RUN: begin
        if (wrap) begin
          round_d      = round_q + 4'd1;
          wrap_pulse_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Output registers; game_over is registered from the next state so it
  // lines up with state.
  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset) begin
      round_q      <= 4'd0;
      wrap_pulse_q <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      round_q      <= round_d;
      wrap_pulse_q <= wrap_pulse_d;
      game_over_q  <= (state_d == DONE);
    end
  end

`ifdef SEG_ROUND_TRACKER_STEP_CHECK_EN
  logic step_err_q, step_err_d;
  logic step_bad;

  // Legal moves are a hold or +1 mod 8; the 3-bit add wraps 7 to 0.
  assign step_bad = prev_valid && (bus.count_in != prev_count) &&
                    (bus.count_in != (prev_count + 3'd1));

  // Sticky flag: set while running, cleared only when a new game starts.
  always_comb begin
    step_err_d = step_err_q;
    if ((state_q == IDLE) && bus.start)    step_err_d = 1'b0;
    else if ((state_q == RUN) && step_bad) step_err_d = 1'b1;
  end

  // Step error register.
  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset) step_err_q <= 1'b0;
    else       step_err_q <= step_err_d;
  end

  assign bus.step_err = step_err_q;
`else
  assign bus.step_err = 1'b0;
`endif

  assign bus.round      = round_q;
  assign bus.state      = state_q;
  assign bus.wrap_pulse = wrap_pulse_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_seg_round_tracker.sv
// ---------------------------------------------------------------------------
// tb_seg_round_tracker
// Drives two trackers (MAX_ROUNDS=3 and the default 9) with identical
// stimulus and checks both against a behavioural game model, plus a table of
// hand-derived expectations for the 3-round game and directed corner cases.
// ---------------------------------------------------------------------------
module tb_seg_round_tracker;

  localparam int ST_IDLE  = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_PAUSE = 2;
  localparam int ST_DONE  = 3;

`ifdef SEG_ROUND_TRACKER_STEP_CHECK_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  typedef struct {
    int rnd;
    int st;
    bit pulse;
    bit err;
    int prev;
    bit pv;
  } model_t;

  typedef struct {
    int c;
    bit s;
    bit p;
    int r;
    int st;
    bit pulse;
  } vec_t;

  logic clk_1H;
  logic reset;
  int   tests;
  int   fails;
  int   cur;
  model_t m3, m9;
  vec_t vecs[$];

  seg_round_tracker_if bus3 ();
  seg_round_tracker_if bus9 ();

  seg_round_tracker #(.MAX_ROUNDS(3)) dut3 (
    .clk_1H (clk_1H),
    .reset  (reset),
    .bus    (bus3)
  );

  seg_round_tracker dut9 (
    .clk_1H (clk_1H),
    .reset  (reset),
    .bus    (bus9)
  );

  always #5 clk_1H = ~clk_1H;

  // Game rules applied to one tick of a model with the given round limit.
  function automatic model_t model_next(input model_t m, input int maxr,
                                        input int c, input bit s, input bit p);
    model_t n;
    bit wrap;
    n = m;
    wrap = m.pv && (m.prev == 7) && (c == 0);
    n.pulse = 1'b0;
    if (m.st == ST_IDLE) begin
      if (s) begin
        n.st = ST_RUN;
        n.rnd = 0;
        n.err = 1'b0;
      end
    end else if (m.st == ST_RUN) begin
      if (STEP_EN && m.pv && (c != m.prev) && (c != (m.prev + 1) % 8))
        n.err = 1'b1;
      if (wrap) begin
        n.rnd = m.rnd + 1;
        n.pulse = 1'b1;
      end
      if (wrap && (m.rnd + 1 == maxr)) n.st = ST_DONE;
      else if (p)                      n.st = ST_PAUSE;
    end else if (m.st == ST_PAUSE) begin
      if (!p) n.st = ST_RUN;
    end else begin
      if (s) n.st = ST_IDLE;
    end
    n.prev = c;
    n.pv = 1'b1;
    return n;
  endfunction

  function automatic model_t model_reset();
    model_t n;
    n.rnd = 0; n.st = ST_IDLE; n.pulse = 0; n.err = 0; n.prev = 0; n.pv = 0;
    return n;
  endfunction

  task automatic compare(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    compare({name, " dut3.round"}, int'(bus3.round), m3.rnd);
    compare({name, " dut3.state"}, int'(bus3.state), m3.st);
    compare({name, " dut3.wrap_pulse"}, int'(bus3.wrap_pulse), int'(m3.pulse));
    compare({name, " dut3.game_over"}, int'(bus3.game_over), int'(m3.st == ST_DONE));
    compare({name, " dut3.step_err"}, int'(bus3.step_err), int'(m3.err));
    compare({name, " dut9.round"}, int'(bus9.round), m9.rnd);
    compare({name, " dut9.state"}, int'(bus9.state), m9.st);
    compare({name, " dut9.wrap_pulse"}, int'(bus9.wrap_pulse), int'(m9.pulse));
    compare({name, " dut9.game_over"}, int'(bus9.game_over), int'(m9.st == ST_DONE));
    compare({name, " dut9.step_err"}, int'(bus9.step_err), int'(m9.err));
  endtask

  // Drive one tick's inputs, clock, update both models and check 1 ns later.
  task automatic applyStimulus(input int c, input bit s, input bit p, input string name);
    bus3.count_in = 3'(c); bus3.start = s; bus3.pause = p;
    bus9.count_in = 3'(c); bus9.start = s; bus9.pause = p;
    cur = c;
    @(posedge clk_1H);
    m3 = model_next(m3, 3, c, s, p);
    m9 = model_next(m9, 9, c, s, p);
    #1;
    checkOutput(name);
  endtask

  task automatic advance(input int n, input bit p, input string name);
    for (int i = 0; i < n; i++) applyStimulus((cur + 1) % 8, 1'b0, p, name);
  endtask

  // Reset in the middle of a low clock phase, checking it acts without an edge.
  task automatic doReset(input string name);
    @(negedge clk_1H);
    bus3.start = 0; bus3.pause = 0;
    bus9.start = 0; bus9.pause = 0;
    reset = 1'b1;
    #1;
    m3 = model_reset();
    m9 = model_reset();
    checkOutput(name);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    vec_t v;
    tests = 0;
    fails = 0;
    cur = 0;
    clk_1H = 1'b0;
    reset = 1'b1;
    bus3.count_in = 0; bus3.start = 0; bus3.pause = 0;
    bus9.count_in = 0; bus9.start = 0; bus9.pause = 0;
    m3 = model_reset();
    m9 = model_reset();

    // 3-round game: expectations for the MAX_ROUNDS=3 instance worked by hand.
    v.c = 0; v.s = 1; v.p = 0; v.r = 0; v.st = ST_RUN; v.pulse = 0;
    vecs.push_back(v);
    for (int lap = 1; lap <= 3; lap++) begin
      for (int c = 1; c <= 7; c++) begin
        v.c = c; v.s = 0; v.p = 0; v.r = lap - 1; v.st = ST_RUN; v.pulse = 0;
        vecs.push_back(v);
      end
      v.c = 0; v.s = 0; v.p = 0; v.r = lap;
      v.st = (lap == 3) ? ST_DONE : ST_RUN; v.pulse = 1;
      vecs.push_back(v);
    end
    v.c = 1; v.s = 0; v.p = 0; v.r = 3; v.st = ST_DONE; v.pulse = 0;
    vecs.push_back(v);

    #3;
    doReset("reset");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].c, vecs[i].s, vecs[i].p, "vec");
      compare("vec round", int'(bus3.round), vecs[i].r);
      compare("vec state", int'(bus3.state), vecs[i].st);
      compare("vec pulse", int'(bus3.wrap_pulse), int'(vecs[i].pulse));
      compare("vec game_over", int'(bus3.game_over), int'(vecs[i].st == ST_DONE));
    end

    // DONE -> IDLE keeps the final round; the next start clears it.
    applyStimulus(2, 1, 0, "done_start");
    compare("done_start state", int'(bus3.state), ST_IDLE);
    compare("done_start round", int'(bus3.round), 3);
    compare("run_start_ignored", int'(bus9.state), ST_RUN);
    applyStimulus(3, 1, 0, "rearm");
    compare("rearm state", int'(bus3.state), ST_RUN);
    compare("rearm round", int'(bus3.round), 0);
    applyStimulus(4, 0, 0, "rearm_hold");

    // Pause across two wraps, then resume and count the next wrap.
    doReset("reset2");
    applyStimulus(0, 1, 0, "start2");
    advance(8, 0, "lap1");
    compare("lap1 round", int'(bus9.round), 1);
    applyStimulus(1, 0, 1, "pause_on");
    compare("pause_on state", int'(bus9.state), ST_PAUSE);
    advance(7, 1, "paused_a");
    compare("paused_a round", int'(bus9.round), 1);
    compare("paused_a pulse", int'(bus9.wrap_pulse), 0);
    advance(8, 1, "paused_b");
    compare("paused_b round", int'(bus9.round), 1);
    compare("paused_b state", int'(bus9.state), ST_PAUSE);
    applyStimulus(1, 0, 0, "resume");
    advance(7, 0, "resume_lap");
    compare("resume round", int'(bus9.round), 2);
    compare("resume pulse", int'(bus9.wrap_pulse), 1);

    // Wrap and pause on the same edge at round 4 of 9.
    advance(8, 0, "lap3");
    advance(8, 0, "lap4");
    advance(7, 0, "to7");
    applyStimulus(0, 0, 1, "wrap_pause");
    compare("wrap_pause round", int'(bus9.round), 5);
    compare("wrap_pause pulse", int'(bus9.wrap_pulse), 1);
    compare("wrap_pause state", int'(bus9.state), ST_PAUSE);
    applyStimulus(1, 0, 1, "wrap_pause_after");
    compare("wrap_pause_after pulse", int'(bus9.wrap_pulse), 0);

    // Illegal step 2 -> 5, flag held through DONE, cleared by the next game.
    doReset("reset3");
    applyStimulus(0, 1, 0, "start3");
    advance(2, 0, "to2");
    applyStimulus(5, 0, 0, "bad_step");
    compare("bad_step err3", int'(bus3.step_err), int'(STEP_EN));
    compare("bad_step err9", int'(bus9.step_err), int'(STEP_EN));
    advance(3, 0, "err_lap1");
    advance(8, 0, "err_lap2");
    advance(8, 0, "err_lap3");
    compare("err_done state", int'(bus3.state), ST_DONE);
    compare("err_done err", int'(bus3.step_err), int'(STEP_EN));
    applyStimulus(1, 1, 0, "err_idle");
    compare("err_idle err", int'(bus3.step_err), int'(STEP_EN));
    applyStimulus(2, 1, 0, "err_clear");
    compare("err_clear err", int'(bus3.step_err), 0);
    compare("err_clear round", int'(bus3.round), 0);

    // Counter at 7 across reset: the 0 after release is not a wrap.
    applyStimulus(7, 0, 0, "pre7");
    doReset("reset4");
    applyStimulus(0, 0, 0, "post_reset0");
    compare("post_reset0 pulse", int'(bus3.wrap_pulse), 0);
    compare("post_reset0 round", int'(bus3.round), 0);
    compare("post_reset0 state", int'(bus3.state), ST_IDLE);

    // Randomised play against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      int c;
      bit s;
      bit p;
      r = int'($urandom_range(0, 99));
      if (r < 80)      c = (cur + 1) % 8;
      else if (r < 90) c = cur;
      else             c = int'($urandom_range(0, 7));
      s = ($urandom_range(0, 99) < 10);
      p = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 199) == 0) doReset("rand_reset");
      applyStimulus(c, s, p, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg_round_tracker.md
SEG_ROUND_TRACKER -- requirements
Module: seg_round_tracker

Interface
REQ-001 Parameter MAX_ROUNDS, default 9: number of counter wraps that ends a game; legal range 1..15.
REQ-002 Port clk_1H  input  1  1 Hz game tick; all state updates on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port count_in  input  3  free-running 0..7 value from the upstream 1 Hz counter.
REQ-005 Port start  input  1  level, sampled each edge; starts or re-arms a game.
REQ-006 Port pause  input  1  level, sampled each edge; holds the game while high.
REQ-007 Port round  output  4  completed-wrap count of the current game, binary.
REQ-008 Port state  output  2  FSM state: IDLE=00, RUN=01, PAUSE=10, DONE=11.
REQ-009 Port wrap_pulse  output  1  one-cycle pulse, registered, for each counted wrap.
REQ-010 Port game_over  output  1  high exactly while state==DONE.
REQ-011 Port step_err  output  1  sticky flag: illegal count_in step seen during RUN.

Function
REQ-012 prev_count (3 bits) SHALL register count_in every edge in every state; prev_valid SHALL set on the first edge after reset.
REQ-013 wrap SHALL be true on an edge when prev_valid=1, prev_count=7 and count_in=0; never while prev_valid=0.
REQ-014 IDLE: start=1 -> RUN, round cleared to 0, step_err cleared; else stay.
REQ-015 RUN: wrap with round<MAX_ROUNDS-1 -> round+1, stay RUN (or PAUSE if pause=1).
REQ-016 RUN: wrap with round=MAX_ROUNDS-1 -> round=MAX_ROUNDS, go DONE; DONE overrides pause.
REQ-017 RUN: pause=1 without terminal wrap -> PAUSE; a non-terminal wrap on the same edge is still counted.
REQ-018 PAUSE: wraps ignored, round held; pause=0 -> RUN.
REQ-019 DONE: round held at MAX_ROUNDS; start=1 -> IDLE (not directly RUN); else stay.
REQ-020 start in RUN or PAUSE SHALL have no effect.
REQ-021 start and pause both high in IDLE -> RUN; pause takes effect on the next edge.
REQ-022 wrap_pulse SHALL be high for exactly the cycle after each edge on which round incremented; never for ignored wraps.
REQ-023 round SHALL never exceed MAX_ROUNDS; no wrap-around of round.
REQ-024 All outputs SHALL be registered; round and state update on the same edge as the wrap that causes them.

Reset
REQ-025 reset high SHALL immediately force state=IDLE, round=0, wrap_pulse=0, step_err=0, prev_count=0, prev_valid=0, regardless of clock.
REQ-026 Reset asserted mid-game SHALL abandon the game; no wrap is detected on the first edge after release.

Configuration
REQ-027 Macro SEG_ROUND_TRACKER_STEP_CHECK_EN defined: in RUN, with prev_valid=1, step_err SHALL set when count_in is neither prev_count nor (prev_count+1) mod 8; cleared only by reset or the IDLE->RUN transition.
REQ-028 Macro undefined: step_err SHALL be constant 0 and no check logic is built; all other behaviour identical.

Verification
REQ-029 Reset release, start=1, count_in 0..7,0 repeated with MAX_ROUNDS=3 -> round 1,2,3 on successive 7->0 edges, wrap_pulse three single-cycle pulses, state=DONE, game_over=1 at third wrap.
REQ-030 RUN round=1, pause=1 across two 7->0 wraps, then pause=0 -> round stays 1 during PAUSE, no wrap_pulse, increments to 2 on next wrap in RUN.
REQ-031 count_in=7 before reset, reset pulse, count_in=0 on first edge after release -> no wrap, round=0, state=IDLE.
REQ-032 RUN round=4, pause=1 on same edge as 7->0 -> round=5, wrap_pulse=1 next cycle, state=PAUSE.
REQ-033 With STEP_CHECK_EN, RUN, count_in 2 -> 5 -> step_err=1, stays 1 through DONE; start from IDLE clears it; without macro step_err=0 throughout.
REQ-034 DONE, start=1 -> IDLE with round=MAX_ROUNDS held; start=1 again -> RUN with round=0.
